// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the memory responder
// Holds the responder state enum, default geometry/latency, and the
// bit-lane index of each byte within a big-endian 32-bit word.
package mem_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    localparam int DEPTH_BYTES_DEF = 16384;
    localparam int LATENCY_DEF     = 2;
    // byte at addr+N lives in byte lane LANE_AN (lane k = bits [8k+7:8k])
    localparam int LANE_A0 = 3;
    localparam int LANE_A1 = 2;
    localparam int LANE_A2 = 1;
    localparam int LANE_A3 = 0;
endpackage

// File: rtl/mem_byte_array.sv
// mem_byte_array: word-organised byte storage with per-lane write enables
// Ports: clk; i_we write strobe; i_addr word index; i_be lane enables
// (bit k = lane k); i_wdata write word; o_rdata combinational read word.
// Contents are never reset.
module mem_byte_array
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_BYTES_DEF / 4,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [3:0]    i_be,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);
    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (i_we && i_be[LANE_A0]) r_mem[i_addr][8*LANE_A0 +: 8] <= i_wdata[8*LANE_A0 +: 8];
        if (i_we && i_be[LANE_A1]) r_mem[i_addr][8*LANE_A1 +: 8] <= i_wdata[8*LANE_A1 +: 8];
        if (i_we && i_be[LANE_A2]) r_mem[i_addr][8*LANE_A2 +: 8] <= i_wdata[8*LANE_A2 +: 8];
        if (i_we && i_be[LANE_A3]) r_mem[i_addr][8*LANE_A3 +: 8] <= i_wdata[8*LANE_A3 +: 8];
    end

    assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory responder with fixed latency
// Ports: clk, rst (async, active-high); request channel req_valid/req_ready
// with req_we, req_addr, req_be, req_wdata; response channel
// rsp_valid/rsp_ready with rsp_rdata, rsp_err (misaligned or out of range).
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_BYTES = DEPTH_BYTES_DEF,
    parameter int LATENCY     = LATENCY_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH_BYTES / 4);

    state_t      r_state, w_state_next;
    logic [3:0]  r_cnt, w_cnt_next;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [3:0]  r_be;
    logic        r_we, r_err;
    logic        w_accept, w_enter, w_err, w_mem_we, w_we;
    logic [31:0] w_addr, w_wdata, w_rdata;
    logic [3:0]  w_be;

    assign req_ready = r_state == IDLE;
    assign rsp_valid = r_state == RESP;
    assign rsp_rdata = rsp_valid ? r_rdata : 32'd0;
    assign rsp_err   = rsp_valid && r_err;
    assign w_accept  = req_valid && req_ready;

    // With LATENCY=1 RESP is entered on the acceptance edge itself, before
    // the request has been captured, so the live request is used there.
    assign w_addr  = r_state == IDLE ? req_addr  : r_addr;
    assign w_we    = r_state == IDLE ? req_we    : r_we;
    assign w_be    = r_state == IDLE ? req_be    : r_be;
    assign w_wdata = r_state == IDLE ? req_wdata : r_wdata;
    // a single compare also catches addr+3 wrapping past 2^32
    assign w_err    = (w_addr[1:0] != 2'd0) || (w_addr > 32'(DEPTH_BYTES - 4));
    assign w_enter  = (w_state_next == RESP) && (r_state != RESP);
    assign w_mem_we = w_enter && w_we && !w_err;

    mem_byte_array #(.DEPTH_WORDS(DEPTH_BYTES / 4), .AW(AW)) u_array (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_addr  (w_addr[AW+1:2]),
        .i_be    (w_be),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: if (req_valid) begin
                w_state_next = LATENCY == 1 ? RESP : ACCESS;
                w_cnt_next   = 4'(LATENCY - 1);
            end
            ACCESS: begin
                w_cnt_next   = r_cnt - 4'd1;
                w_state_next = w_cnt_next == 4'd0 ? RESP : ACCESS;
            end
            RESP: if (rsp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_be    <= 4'd0;
            r_we    <= 1'b0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_be    <= req_be;
                r_we    <= req_we;
            end
            if (w_enter) begin
                r_err   <= w_err;
                r_rdata <= (w_err || w_we) ? 32'd0 : w_rdata;
            end
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized self-checking bench against a byte-array model
module tb_mem_responder;
    import mem_pkg::*;
    localparam int DEPTH  = 16384;
    localparam int WORDS  = DEPTH / 4;
    localparam int DEPTH1 = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        b_req_valid = 1'b0;
    logic [31:0] b_req_addr = '0;
    logic        b_req_ready, b_rsp_valid, b_rsp_err;
    logic [31:0] b_rsp_rdata;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] model [DEPTH];

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    mem_responder #(.DEPTH_BYTES(DEPTH1), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_we(1'b0), .req_addr(b_req_addr), .req_be(4'h0), .req_wdata(32'h0),
        .rsp_valid(b_rsp_valid), .rsp_ready(1'b1), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    // Model: flat byte memory; a word is the 4 bytes starting at addr, first byte most significant.
    task automatic model_txn(input logic we, input logic [31:0] a, input logic [3:0] be,
                             input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int base;
        er = (a % 4 != 0) || (64'(a) + 4 > 64'(DEPTH));
        rd = 32'd0;
        base = int'(a);
        if (!er) begin
            for (int i = 0; i < 4; i++) begin
                if (we && be[3-i]) model[base+i] = wd[31-8*i -: 8];
                if (!we) rd = (rd << 8) | 32'(model[base+i]);
            end
        end
    endtask

    task automatic txn(input logic we, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lat);
        int w;
        @(negedge clk);
        req_we = we; req_addr = a; req_be = be; req_wdata = wd; req_valid = 1'b1;
        w = 0;
        while (!req_ready && w < 100) begin @(negedge clk); w++; end
        if (!req_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: req_ready=0 after %0d cycles, want 1", w);
        end
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 100) begin @(negedge clk); lat++; end
        rd = rsp_rdata; er = rsp_err; rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic preload();
        logic [31:0] v;
        for (int w = 0; w < WORDS; w++) begin
            v = (w == 0) ? 32'h014b4820 : $urandom;
            dut.u_array.r_mem[w] = v;
            for (int i = 0; i < 4; i++) model[4*w+i] = v[31-8*i -: 8];
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp += 4;
        if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        if (rsp_rdata !== 32'd0) begin n_bad++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
        if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
        rst = 1'b0;
    endtask

    task automatic test_read_preload();
        logic [31:0] rd; logic er; int lat;
        txn(1'b0, 32'd0, 4'h0, 32'd0, rd, er, lat);
        n_cmp += 3;
        if (rd !== 32'h014b4820) begin n_bad++; $display("FAIL read0_data: got %h want 014b4820", rd); end
        if (er !== 1'b0) begin n_bad++; $display("FAIL read0_err: got %b want 0", er); end
        if (lat != 2) begin n_bad++; $display("FAIL read0_latency: got %0d want 2", lat); end
    endtask

    task automatic test_write_be();
        logic [31:0] rd, mrd; logic er, mer; int lat;
        txn(1'b1, 32'd100, 4'hf, 32'h0000000a, rd, er, lat);
        model_txn(1'b1, 32'd100, 4'hf, 32'h0000000a, mrd, mer);
        n_cmp += 2;
        if (er !== 1'b0 || rd !== 32'd0) begin n_bad++; $display("FAIL write_full_rsp: got err %b data %h want 0/0", er, rd); end
        txn(1'b0, 32'd100, 4'h0, 32'd0, rd, er, lat);
        if (rd !== 32'h0000000a) begin n_bad++; $display("FAIL read_after_write: got %h want 0000000a", rd); end
        txn(1'b1, 32'd100, 4'h1, 32'hffffffff, rd, er, lat);
        model_txn(1'b1, 32'd100, 4'h1, 32'hffffffff, mrd, mer);
        txn(1'b0, 32'd100, 4'h0, 32'd0, rd, er, lat);
        n_cmp++;
        if (rd !== 32'h000000ff) begin n_bad++; $display("FAIL read_after_be0001: got %h want 000000ff", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd, mrd; logic er, mer; int lat;
        txn(1'b0, 32'd2, 4'h0, 32'd0, rd, er, lat);
        n_cmp += 2;
        if (er !== 1'b1) begin n_bad++; $display("FAIL misaligned_err: got %b want 1", er); end
        if (rd !== 32'd0) begin n_bad++; $display("FAIL misaligned_data: got %h want 0", rd); end
        txn(1'b1, 32'(DEPTH - 2), 4'hf, 32'h12345678, rd, er, lat);
        n_cmp++;
        if (er !== 1'b1) begin n_bad++; $display("FAIL oor_write_err: got %b want 1", er); end
        model_txn(1'b0, 32'(DEPTH - 4), 4'h0, 32'd0, mrd, mer);
        txn(1'b0, 32'(DEPTH - 4), 4'h0, 32'd0, rd, er, lat);
        n_cmp += 2;
        if (er !== 1'b0) begin n_bad++; $display("FAIL last_word_err: got %b want 0", er); end
        if (rd !== mrd) begin n_bad++; $display("FAIL last_word_unchanged: got %h want %h", rd, mrd); end
        txn(1'b0, 32'hfffffffc, 4'h0, 32'd0, rd, er, lat);
        n_cmp++;
        if (er !== 1'b1) begin n_bad++; $display("FAIL wrap_addr_err: got %b want 1", er); end
    endtask

    task automatic test_stall();
        logic [31:0] ea, eb, rd; logic er; int w, lat;
        logic [31:0] a, b;
        a = {18'd0, 12'($urandom_range(0, WORDS - 1)), 2'b00};
        b = {18'd0, 12'($urandom_range(0, WORDS - 1)), 2'b00};
        model_txn(1'b0, a, 4'h0, 32'd0, ea, er);
        model_txn(1'b0, b, 4'h0, 32'd0, eb, er);
        @(negedge clk);
        req_we = 1'b0; req_addr = a; req_valid = 1'b1;
        w = 0;
        while (!req_ready && w < 100) begin @(negedge clk); w++; end
        @(negedge clk);
        req_valid = 1'b0;
        w = 0;
        while (!rsp_valid && w < 100) begin @(negedge clk); w++; end
        req_addr = b; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp += 3;
            if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid[%0d]: got %b want 1", i, rsp_valid); end
            if (rsp_rdata !== ea) begin n_bad++; $display("FAIL stall_data[%0d]: got %h want %h", i, rsp_rdata, ea); end
            if (req_ready !== 1'b0) begin n_bad++; $display("FAIL stall_req_ready[%0d]: got %b want 0", i, req_ready); end
        end
        rsp_ready = 1'b1;
        n_cmp++;
        if (req_ready !== 1'b0) begin n_bad++; $display("FAIL handshake_req_ready: got %b want 0", req_ready); end
        @(negedge clk);
        rsp_ready = 1'b0;
        n_cmp += 2;
        if (req_ready !== 1'b1) begin n_bad++; $display("FAIL post_hs_req_ready: got %b want 1", req_ready); end
        if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL post_hs_rsp_valid: got %b want 0", rsp_valid); end
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 100) begin @(negedge clk); lat++; end
        rd = rsp_rdata;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_cmp += 2;
        if (lat != 2) begin n_bad++; $display("FAIL held_req_latency: got %0d want 2", lat); end
        if (rd !== eb) begin n_bad++; $display("FAIL held_req_data: got %h want %h", rd, eb); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd, mrd; logic er, mer; int w, lat;
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'd8; req_be = 4'hf; req_wdata = 32'hdeadbeef; req_valid = 1'b1;
        w = 0;
        while (!req_ready && w < 100) begin @(negedge clk); w++; end
        @(negedge clk);
        req_valid = 1'b0;
        n_cmp++;
        if (req_ready !== 1'b0) begin n_bad++; $display("FAIL abort_in_flight: req_ready got %b want 0", req_ready); end
        #1 rst = 1'b1;
        #1;
        n_cmp += 2;
        if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL abort_rsp_valid: got %b want 0", rsp_valid); end
        if (req_ready !== 1'b1) begin n_bad++; $display("FAIL abort_req_ready: got %b want 1", req_ready); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_txn(1'b0, 32'd8, 4'h0, 32'd0, mrd, mer);
        txn(1'b0, 32'd8, 4'h0, 32'd0, rd, er, lat);
        n_cmp++;
        if (rd !== mrd) begin n_bad++; $display("FAIL abort_no_write: got %h want %h", rd, mrd); end
    endtask

    task automatic test_random();
        logic [31:0] a, wd, rd, mrd; logic [3:0] be; logic we, er, mer; int lat, k;
        for (int t = 0; t < 300; t++) begin
            k = $urandom_range(0, 9);
            we = 1'($urandom);
            be = 4'($urandom);
            wd = $urandom;
            a = k == 0 ? 32'($urandom_range(0, DEPTH - 1)) | 32'd1 :
                k == 1 ? 32'($urandom_range(DEPTH - 3, DEPTH + 64)) :
                k < 5  ? {24'd0, 6'($urandom), 2'b00} :
                         {18'd0, 12'($urandom), 2'b00};
            model_txn(we, a, be, wd, mrd, mer);
            txn(we, a, be, wd, rd, er, lat);
            n_cmp += 3;
            if (rd !== mrd) begin n_bad++; $display("FAIL rand_data[%0d] addr %h we %b: got %h want %h", t, a, we, rd, mrd); end
            if (er !== mer) begin n_bad++; $display("FAIL rand_err[%0d] addr %h: got %b want %b", t, a, er, mer); end
            if (lat != 2) begin n_bad++; $display("FAIL rand_latency[%0d]: got %0d want 2", t, lat); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w0, w1;
        w0 = $urandom;
        w1 = $urandom;
        dut1.u_array.r_mem[0] = w0;
        dut1.u_array.r_mem[1] = w1;
        @(negedge clk);
        b_req_addr = 32'd0; b_req_valid = 1'b1;
        n_cmp++;
        if (b_req_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_accept0: req_ready got %b want 1", b_req_ready); end
        @(negedge clk);
        n_cmp += 3;
        if (b_rsp_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_rsp0_valid: got %b want 1", b_rsp_valid); end
        if (b_rsp_rdata !== w0) begin n_bad++; $display("FAIL b2b_rsp0_data: got %h want %h", b_rsp_rdata, w0); end
        if (b_req_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_busy: req_ready got %b want 0", b_req_ready); end
        b_req_addr = 32'd4;
        @(negedge clk);
        n_cmp += 2;
        if (b_req_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_accept1: req_ready got %b want 1", b_req_ready); end
        if (b_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_gap_valid: got %b want 0", b_rsp_valid); end
        @(negedge clk);
        b_req_valid = 1'b0;
        n_cmp += 3;
        if (b_rsp_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_rsp1_valid: got %b want 1", b_rsp_valid); end
        if (b_rsp_rdata !== w1) begin n_bad++; $display("FAIL b2b_rsp1_data: got %h want %h", b_rsp_rdata, w1); end
        if (b_rsp_err !== 1'b0) begin n_bad++; $display("FAIL b2b_rsp1_err: got %b want 0", b_rsp_err); end
        @(negedge clk);
    endtask

    initial begin
        preload();
        test_reset();
        test_read_preload();
        test_write_be();
        test_errors();
        test_stall();
        test_reset_abort();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
